// File: rtl/regfile_pkg.sv
// Shared sizing constants and FSM state type for the register file store.
// Imported by the interface, the decoder and the top.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int WIDTH    = 64;
  localparam int ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_file_store_if.sv
// Bus bundle for reg_file_store: write port, two read ports, full
// register dump (read_list) and the bulk-clear request/status lines.
interface reg_file_store_if #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int WIDTH    = regfile_pkg::WIDTH
);

  logic                           wr_en;
  logic [4:0]                     wr_addr;
  logic [WIDTH-1:0]               wr_data;
  logic [4:0]                     rd_addr1;
  logic [4:0]                     rd_addr2;
  logic [WIDTH-1:0]               rd_data1;
  logic [WIDTH-1:0]               rd_data2;
  logic [NUM_REGS-1:0][WIDTH-1:0] read_list;
  logic                           clr_req;
  logic                           clr_busy;
  logic                           clr_done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_addr1, rd_addr2, clr_req,
    input  rd_data1, rd_data2, read_list,
    input  clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_addr1, rd_addr2, clr_req,
    output rd_data1, rd_data2, read_list,
    output clr_busy, clr_done
  );

endinterface

// File: rtl/reg_write_decoder.sv
// 5-to-32 one-hot register write-select decoder gated by i_en.
// Ports: i_en (effective write enable), i_addr, o_sel (one-hot).
module reg_write_decoder #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                i_en,
  input  logic [4:0]          i_addr,
  output logic [NUM_REGS-1:0] o_sel
);

  always_comb begin
    o_sel = '0;
    if (i_en) o_sel[i_addr] = 1'b1;
  end

endmodule

// File: rtl/reg_file_store.sv
// Register file: 1W/2R with write bypass, full dump, bulk-clear FSM.
// Ports: clk, reset_n (async, active-low), bus (reg_file_store_if.slave).
module reg_file_store #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int WIDTH    = regfile_pkg::WIDTH
) (
  input logic            clk,
  input logic            reset_n,
  reg_file_store_if.slave bus
);

  import regfile_pkg::*;

  state_e                         r_state;
  logic [4:0]                     r_idx;
  logic [NUM_REGS-1:0][WIDTH-1:0] r_regs;

  logic                           w_idle;
  logic                           w_we;
  logic [NUM_REGS-1:0]            w_wsel;
  logic [WIDTH-1:0]               w_rd1;
  logic [WIDTH-1:0]               w_rd2;

  assign w_idle = (r_state == IDLE);

  // reset_n term keeps the bypass path from leaking wr_data
  // onto the read ports while reset is held.
  assign w_we = bus.wr_en & w_idle & reset_n
              & (bus.wr_addr != ZERO_REG);

  reg_write_decoder #(
    .NUM_REGS (NUM_REGS)
  ) u_dec (
    .i_en   (w_we),
    .i_addr (bus.wr_addr),
    .o_sel  (w_wsel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.clr_req) begin
            r_state <= CLEAR;
            r_idx   <= '0;
          end
        end
        CLEAR: begin
          if (r_idx == ZERO_REG - 5'd1) begin
            r_state <= DONE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 5'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Entry ZERO_REG is never selected by w_wsel nor by the clear
  // index, so it holds its reset value of zero forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_state == CLEAR && r_idx == 5'(i))
          r_regs[i] <= '0;
        else if (w_wsel[i])
          r_regs[i] <= bus.wr_data;
      end
    end
  end

  always_comb begin
    w_rd1 = r_regs[bus.rd_addr1];
    if (w_we && bus.wr_addr == bus.rd_addr1)
      w_rd1 = bus.wr_data;
  end

  always_comb begin
    w_rd2 = r_regs[bus.rd_addr2];
    if (w_we && bus.wr_addr == bus.rd_addr2)
      w_rd2 = bus.wr_data;
  end

  assign bus.rd_data1  = w_rd1;
  assign bus.rd_data2  = w_rd2;
  assign bus.read_list = r_regs;
  assign bus.clr_busy  = (r_state == CLEAR);
  assign bus.clr_done  = (r_state == DONE);

endmodule

// File: tb/tb_reg_file_store.sv
// Self-checking bench for reg_file_store: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_reg_file_store;

  localparam int NR = 32;
  localparam int W  = 64;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  reg_file_store_if bus ();

  reg_file_store dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] model [NR];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    bus.clr_req  = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic write_reg(input logic [4:0] a, input logic [W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    if (a != 5'd31) model[a] = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd4;
    bus.wr_data  = rnd64();
    bus.rd_addr1 = 5'd4;
    bus.rd_addr2 = 5'd4;
    reset_n      = 1'b0;
    #1;
    n_cmp++;
    if (bus.rd_data1 !== '0 || bus.rd_data2 !== '0) begin
      n_err++;
      $display("FAIL reset_rd: rd1=%h rd2=%h want 0",
               bus.rd_data1, bus.rd_data2);
    end
    step();
    n_cmp++;
    if (bus.read_list !== '0) begin
      n_err++;
      $display("FAIL reset_list: read_list not all zero");
    end
    n_cmp++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: busy=%b done=%b want 0/0",
               bus.clr_busy, bus.clr_done);
    end
    idle_inputs();
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    step();
  endtask

  task automatic test_directed();
    logic [W-1:0] prev;
    write_reg(5'd5, 64'h0123_4567_89AB_CDEF);
    bus.rd_addr1 = 5'd5;
    #1;
    n_cmp++;
    if (bus.rd_data1 !== 64'h0123_4567_89AB_CDEF) begin
      n_err++;
      $display("FAIL x5_rd1: got %h want %h",
               bus.rd_data1, 64'h0123_4567_89AB_CDEF);
    end
    n_cmp++;
    if (bus.read_list[5] !== 64'h0123_4567_89AB_CDEF) begin
      n_err++;
      $display("FAIL x5_list: got %h want %h",
               bus.read_list[5], 64'h0123_4567_89AB_CDEF);
    end
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd31;
    bus.wr_data  = '1;
    bus.rd_addr2 = 5'd31;
    #1;
    n_cmp++;
    if (bus.rd_data2 !== '0) begin
      n_err++;
      $display("FAIL x31_bypass: got %h want 0", bus.rd_data2);
    end
    step();
    bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.rd_data2 !== '0 || bus.read_list[31] !== '0) begin
      n_err++;
      $display("FAIL x31_store: rd2=%h list=%h want 0",
               bus.rd_data2, bus.read_list[31]);
    end
    prev         = model[7];
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 64'hDEAD_BEEF;
    bus.rd_addr1 = 5'd7;
    bus.rd_addr2 = 5'd7;
    #1;
    n_cmp++;
    if (bus.rd_data1 !== 64'hDEAD_BEEF ||
        bus.rd_data2 !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL x7_bypass: rd1=%h rd2=%h want deadbeef",
               bus.rd_data1, bus.rd_data2);
    end
    n_cmp++;
    if (bus.read_list[7] !== prev) begin
      n_err++;
      $display("FAIL x7_list_early: got %h want %h",
               bus.read_list[7], prev);
    end
    step();
    bus.wr_en = 1'b0;
    model[7]  = 64'hDEAD_BEEF;
    n_cmp++;
    if (bus.read_list[7] !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL x7_list_late: got %h want deadbeef",
               bus.read_list[7]);
    end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] e1, e2;
    int j;
    for (int it = 0; it < n; it++) begin
      bus.wr_en    = ($urandom_range(0, 2) != 0);
      bus.wr_addr  = 5'($urandom_range(0, 31));
      bus.wr_data  = rnd64();
      bus.rd_addr1 = ($urandom_range(0, 3) == 0) ? bus.wr_addr
                                                 : 5'($urandom_range(0, 31));
      bus.rd_addr2 = ($urandom_range(0, 3) == 0) ? bus.rd_addr1
                                                 : 5'($urandom_range(0, 31));
      j = $urandom_range(0, NR - 1);
      #1;
      e1 = model[bus.rd_addr1];
      e2 = model[bus.rd_addr2];
      if (bus.wr_en && bus.wr_addr != 5'd31) begin
        if (bus.rd_addr1 == bus.wr_addr) e1 = bus.wr_data;
        if (bus.rd_addr2 == bus.wr_addr) e2 = bus.wr_data;
      end
      n_cmp++;
      if (bus.rd_data1 !== e1) begin
        n_err++;
        $display("FAIL rand_rd1[%0d]: got %h want %h",
                 bus.rd_addr1, bus.rd_data1, e1);
      end
      n_cmp++;
      if (bus.rd_data2 !== e2) begin
        n_err++;
        $display("FAIL rand_rd2[%0d]: got %h want %h",
                 bus.rd_addr2, bus.rd_data2, e2);
      end
      n_cmp++;
      if (bus.read_list[j] !== model[j]) begin
        n_err++;
        $display("FAIL rand_list[%0d]: got %h want %h",
                 j, bus.read_list[j], model[j]);
      end
      step();
      if (bus.wr_en && bus.wr_addr != 5'd31)
        model[bus.wr_addr] = bus.wr_data;
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    for (int i = 0; i < NR; i++) write_reg(5'(i), rnd64());
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (bus.read_list[i] !== model[i]) begin
        n_err++;
        $display("FAIL load_list[%0d]: got %h want %h",
                 i, bus.read_list[i], model[i]);
      end
    end
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.clr_busy) busy_cnt++;
      if (bus.clr_done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 5) begin
        n_cmp++;
        if (bus.read_list[20] !== model[20]) begin
          n_err++;
          $display("FAIL clr_partial[20]: got %h want %h",
                   bus.read_list[20], model[20]);
        end
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 5'd2;
        bus.wr_data  = rnd64() | 64'h1;
        bus.rd_addr1 = 5'd2;
        #1;
        n_cmp++;
        if (bus.rd_data1 !== '0) begin
          n_err++;
          $display("FAIL clr_nobypass: got %h want 0", bus.rd_data1);
        end
      end
      step();
      bus.wr_en = 1'b0;
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
    n_cmp++;
    if (busy_cnt != 31) begin
      n_err++;
      $display("FAIL clr_busy_cycles: got %0d want 31", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 31) begin
      n_err++;
      $display("FAIL clr_done_pulse: count %0d at %0d want 1 at 31",
               done_cnt, done_at);
    end
    for (int i = 0; i < NR; i++) begin
      n_cmp++;
      if (bus.read_list[i] !== '0) begin
        n_err++;
        $display("FAIL clr_list[%0d]: got %h want 0",
                 i, bus.read_list[i]);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    bit bad = 1'b0;
    for (int i = 0; i < 31; i++) write_reg(5'(i), rnd64() | 64'h1);
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (10) step();
    n_cmp++;
    if (bus.clr_busy !== 1'b1 || bus.read_list[20] !== model[20]) begin
      n_err++;
      $display("FAIL midclr_pre: busy=%b x20=%h want 1/%h",
               bus.clr_busy, bus.read_list[20], model[20]);
    end
    #1;
    reset_n      = 1'b0;
    bus.rd_addr1 = 5'd20;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    n_cmp++;
    if (bus.read_list !== '0 || bus.rd_data1 !== '0) begin
      n_err++;
      $display("FAIL midclr_zero: x20=%h rd1=%h want 0",
               bus.read_list[20], bus.rd_data1);
    end
    n_cmp++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL midclr_flags: busy=%b done=%b want 0/0",
               bus.clr_busy, bus.clr_done);
    end
    #2;
    reset_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL midclr_after: busy/done seen %b want 0", bad);
    end
    write_reg(5'd9, 64'h9999);
    n_cmp++;
    if (bus.read_list[9] !== 64'h9999) begin
      n_err++;
      $display("FAIL midclr_idle_wr: got %h want 9999",
               bus.read_list[9]);
    end
  endtask

  task automatic test_clr_and_write();
    int k;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 64'h55;
    bus.clr_req = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (bus.read_list[3] !== 64'h55 || bus.clr_busy !== 1'b1) begin
      n_err++;
      $display("FAIL cw_first: x3=%h busy=%b want 55/1",
               bus.read_list[3], bus.clr_busy);
    end
    k = 0;
    while (!bus.clr_done && k < 40) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.clr_done !== 1'b1) begin
      n_err++;
      $display("FAIL cw_timeout: done=%b after %0d cycles want 1",
               bus.clr_done, k);
    end
    step();
    for (int i = 0; i < NR; i++) model[i] = '0;
    n_cmp++;
    if (bus.read_list[3] !== '0 || bus.clr_busy !== 1'b0) begin
      n_err++;
      $display("FAIL cw_final: x3=%h busy=%b want 0/0",
               bus.read_list[3], bus.clr_busy);
    end
  endtask

  task automatic test_clr_held();
    int k = 0;
    bus.clr_req = 1'b1;
    step();
    while (!bus.clr_done && k < 40) begin
      step();
      k++;
    end
    n_cmp++;
    if (bus.clr_done !== 1'b1) begin
      n_err++;
      $display("FAIL held_timeout: done=%b want 1", bus.clr_done);
    end
    step();
    n_cmp++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle: busy=%b done=%b want 0/0",
               bus.clr_busy, bus.clr_done);
    end
    step();
    bus.clr_req = 1'b0;
    n_cmp++;
    if (bus.clr_busy !== 1'b1) begin
      n_err++;
      $display("FAIL held_restart: busy=%b want 1", bus.clr_busy);
    end
    k = 0;
    while (!bus.clr_done && k < 40) begin
      step();
      k++;
    end
    step();
    n_cmp++;
    if (bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) begin
      n_err++;
      $display("FAIL held_end: busy=%b done=%b want 0/0",
               bus.clr_busy, bus.clr_done);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(300);
    test_clear();
    test_random(100);
    test_reset_mid_clear();
    test_clr_and_write();
    test_clr_held();
    test_random(100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
